mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage RISC-V core.
- Captures MEM-stage results, performs load byte/halfword extraction and sign/zero extension, and selects ALU versus load data.
- Drives the register file write port (RDaddr/RDdata/RegWrite) and the WB forwarding path.
- The register file writes on the negedge, so data launched from this stage's posedge is visible to ID reads in the same cycle.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- CNT_W, 32, retire counter width (used only with WB_INSTRET_EN).

Ports:
- clk  input  1  clock; all flops update on posedge.
- rst_n  input  1  asynchronous, active-high reset: a 1 clears the block immediately, independent of clk.
- valid_i  input  1  MEM stage holds a valid instruction.
- RegWrite_i  input  1  instruction writes rd.
- MemToReg_i  input  1  1 selects load data, 0 selects ALU result.
- funct3_i  input  3  load type.
- RDaddr_i  input  REG_AW  destination register.
- ALUresult_i  input  XLEN  ALU result or load address.
- MemData_i  input  XLEN  raw aligned 32-bit word read from data memory.
- stall_i  input  1  hold the pipeline register.
- flush_i  input  1  kill the captured instruction.
- RDaddr_o  output  REG_AW  register file write address.
- RDdata_o  output  XLEN  register file write data.
- RegWrite_o  output  1  register file write enable.
- fwd_valid_o  output  1  WB forwarding valid; equals RegWrite_o.
- misalign_o  output  1  captured load is misaligned.
- illegal_o  output  1  captured load has a reserved funct3.
- instret_o  output  CNT_W  retired-instruction count (only with WB_INSTRET_EN).

Behaviour:
- Reset (rst_n=1): valid_q, regwrite_q, memtoreg_q, rd_q, alu_q, memdata_q, funct3_q and instret all go to 0. Every output therefore reads 0.
- Reset is honoured mid-operation; the first capture occurs on the first posedge after rst_n falls.
- Capture priority at posedge:
  - flush_i=1: valid_q<=0, other fields don't-care. Flush beats stall.
  - else stall_i=1: all fields hold.
  - else: all fields load from the *_i inputs.
- Latency: 1 cycle from MEM inputs to WB outputs. The register file commits on the following negedge.
- Load extraction, combinational on the q fields; byte select is alu_q[1:0], halfword select is alu_q[1]:
  - 000 LB: sign-extended byte.
  - 100 LBU: zero-extended byte.
  - 001 LH: sign-extended halfword.
  - 101 LHU: zero-extended halfword.
  - 010 LW: full word.
- misalign_o = valid_q & memtoreg_q & ((LH/LHU & alu_q[0]) | (LW & alu_q[1:0]!=0)).
- illegal_o = valid_q & memtoreg_q & funct3_q in {011,110,111}.
- RDdata_o = memtoreg_q ? extracted load : alu_q. On a misaligned or illegal load, RDdata_o = 0.
- RegWrite_o = valid_q & regwrite_q & (rd_q!=0) & ~misalign_o & ~illegal_o.
- x0 is never written from this stage.
- During a stall, outputs hold and RegWrite_o stays asserted. Rewriting the same value each negedge is idempotent and required.
- RDaddr_o = rd_q, driven even when RegWrite_o=0.
- misalign_o and illegal_o are level outputs: they last as long as the instruction occupies WB, including stalled cycles.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - CNT_W-bit counter increments at each posedge where valid_q=1 and stall_i=0, i.e. an instruction leaves WB.
  - Flushed bubbles and stalled cycles do not count.
  - Misaligned and illegal loads do count.
  - Wraps from all-ones to 0.
  - Cleared by reset.
- Undefined: no counter flops; instret_o is tied to 0.

Test Plan:
- ADD: valid_i=1, RegWrite_i=1, MemToReg_i=0, RDaddr_i=5, ALUresult_i=0x12345678 -> next cycle RDaddr_o=5, RDdata_o=0x12345678, RegWrite_o=1. Register file x5=0x12345678 after the negedge.
- Loads with MemData_i=0x80FF7F01:
  - LB at addr 0x103 -> 0xFFFFFF80.
  - LBU at addr 0x102 -> 0x000000FF.
  - LH at addr 0x100 -> 0x00007F01.
  - LHU at addr 0x102 -> 0x000080FF.
  - Each with RegWrite_o=1.
- Misaligned LW at addr 0x101 -> misalign_o=1, RegWrite_o=0, RDdata_o=0. Write with RDaddr_i=0 -> RegWrite_o=0.
- Stall then flush:
  - Capture an instruction, then stall_i=1 for 3 cycles -> outputs held and RegWrite_o=1 throughout.
  - Then assert flush_i=1 together with stall_i=1 -> next cycle RegWrite_o=0.
- Assert rst_n=1 between clock edges while RegWrite_o=1 -> all outputs 0 immediately, before the next posedge.
- WB_INSTRET_EN:
  - 10 valid instructions, 2 flushed, 3 stall cycles -> instret_o=10.
  - Preload the counter near the max value -> wraps to 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and writeback logic for the 5-stage RISC-V core.
// Captures the MEM-stage result, extracts and extends load bytes/halfwords
// from the aligned data-memory word, and selects ALU versus load data for the
// register file write port. The register file writes on the negedge, so data
// launched here on the posedge is readable by ID in the same cycle.
//
// Optional build macro:
//   WB_INSTRET_EN  - when defined, a CNT_W-bit retired-instruction counter is
//                    built and driven on instret_o; otherwise instret_o is 0.
//
// Ports:
//   clk          in   clock, all flops update on posedge
//   rst_n        in   asynchronous reset, ACTIVE HIGH despite the name
//   valid_i      in   MEM stage holds a valid instruction
//   RegWrite_i   in   instruction writes rd
//   MemToReg_i   in   1 = load data, 0 = ALU result
//   funct3_i     in   load type
//   RDaddr_i     in   destination register
//   ALUresult_i  in   ALU result or load address
//   MemData_i    in   raw aligned word read from data memory
//   stall_i      in   hold the pipeline register
//   flush_i      in   kill the captured instruction (beats stall)
//   RDaddr_o     out  register file write address (always rd_q)
//   RDdata_o     out  register file write data
//   RegWrite_o   out  register file write enable
//   fwd_valid_o  out  WB forwarding valid (same as RegWrite_o)
//   misalign_o   out  captured load is misaligned
//   illegal_o    out  captured load has a reserved funct3
//   instret_o    out  retired-instruction count
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [2:0]        funct3_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic [XLEN-1:0]   ALUresult_i,
  input  logic [XLEN-1:0]   MemData_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [XLEN-1:0]   RDdata_o,
  output logic              RegWrite_o,
  output logic              fwd_valid_o,
  output logic              misalign_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  instret_o
);

  typedef enum logic [2:0] {
    LD_B   = 3'b000,
    LD_H   = 3'b001,
    LD_W   = 3'b010,
    LD_R3  = 3'b011,
    LD_BU  = 3'b100,
    LD_HU  = 3'b101,
    LD_R6  = 3'b110,
    LD_R7  = 3'b111
  } ld_e;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  ld_e               funct3_q,   funct3_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   alu_q,      alu_d;
  logic [XLEN-1:0]   memdata_q,  memdata_d;

  // ---------------------------------------------------------------------------
  // Pipeline register capture: flush > stall > load.
  // On flush only valid is cleared; the remaining fields simply hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    memdata_d  = memdata_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = RegWrite_i;
      memtoreg_d = MemToReg_i;
      funct3_d   = ld_e'(funct3_i);
      rd_d       = RDaddr_i;
      alu_d      = ALUresult_i;
      memdata_d  = MemData_i;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      funct3_q   <= LD_B;
      rd_q       <= '0;
      alu_q      <= '0;
      memdata_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      memdata_q  <= memdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction. Byte lane from alu_q[1:0], halfword lane from alu_q[1].
  // ---------------------------------------------------------------------------
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    byte_v = memdata_q[7:0];
    case (alu_q[1:0])
      2'd0:    byte_v = memdata_q[7:0];
      2'd1:    byte_v = memdata_q[15:8];
      2'd2:    byte_v = memdata_q[23:16];
      default: byte_v = memdata_q[31:24];
    endcase
    half_v = alu_q[1] ? memdata_q[31:16] : memdata_q[15:0];
  end

  always_comb begin
    ld_data = '0;
    case (funct3_q)
      LD_B: begin
        ld_data       = {XLEN{byte_v[7]}};
        ld_data[7:0]  = byte_v;
      end
      LD_BU: begin
        ld_data[7:0]  = byte_v;
      end
      LD_H: begin
        ld_data       = {XLEN{half_v[15]}};
        ld_data[15:0] = half_v;
      end
      LD_HU: begin
        ld_data[15:0] = half_v;
      end
      LD_W: begin
        ld_data       = memdata_q;
      end
      default: begin
        ld_data       = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Exception flags and writeback selection.
  // ---------------------------------------------------------------------------
  logic is_load;
  logic half_mis;
  logic word_mis;
  logic bad_f3;

  always_comb begin
    is_load  = valid_q & memtoreg_q;
    half_mis = ((funct3_q == LD_H) || (funct3_q == LD_HU)) && alu_q[0];
    word_mis = (funct3_q == LD_W) && (alu_q[1:0] != 2'b00);
    bad_f3   = (funct3_q == LD_R3) || (funct3_q == LD_R6) || (funct3_q == LD_R7);
  end

  assign misalign_o = is_load & (half_mis | word_mis);
  assign illegal_o  = is_load & bad_f3;

  // A faulting load must not leak partial memory data onto the write port.
  always_comb begin
    if (misalign_o || illegal_o) begin
      RDdata_o = '0;
    end else if (memtoreg_q) begin
      RDdata_o = ld_data;
    end else begin
      RDdata_o = alu_q;
    end
  end

  assign RegWrite_o  = valid_q & regwrite_q & (rd_q != '0) & ~misalign_o & ~illegal_o;
  assign fwd_valid_o = RegWrite_o;
  assign RDaddr_o    = rd_q;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter: an instruction retires when it leaves WB,
  // i.e. valid_q is set and the stage is not stalled. Faulting loads count.
  // ---------------------------------------------------------------------------
`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (valid_q && !stall_i) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

`ifdef WB_INSTRET_EN
  localparam int unsigned TB_CNT_W = 4;
`else
  localparam int unsigned TB_CNT_W = 32;
`endif

  localparam logic [31:0] M = 32'h80FF7F01;

  logic        clk;
  logic        rst_n;
  logic        valid_i, RegWrite_i, MemToReg_i, stall_i, flush_i;
  logic [2:0]  funct3_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] ALUresult_i, MemData_i;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o, fwd_valid_o, misalign_o, illegal_o;
  logic [TB_CNT_W-1:0] instret_o;

  mem_wb_stage #(
    .XLEN   (32),
    .REG_AW (5),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .RegWrite_i  (RegWrite_i),
    .MemToReg_i  (MemToReg_i),
    .funct3_i    (funct3_i),
    .RDaddr_i    (RDaddr_i),
    .ALUresult_i (ALUresult_i),
    .MemData_i   (MemData_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o),
    .RegWrite_o  (RegWrite_o),
    .fwd_valid_o (fwd_valid_o),
    .misalign_o  (misalign_o),
    .illegal_o   (illegal_o),
    .instret_o   (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model, written on the negedge like the real one.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (RegWrite_o) rf[RDaddr_o] <= RDdata_o;
  end

  typedef struct {
    string       tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        mis;
    logic        ill;
    bit          full;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Independent retire model.
  logic                m_valid = 1'b0;
  logic [TB_CNT_W-1:0] m_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [4:0] rd, input logic [31:0] data,
                              input logic we, input logic mis, input logic ill, input bit full);
    exp_t e;
    e.tag = tag; e.rd = rd; e.data = data; e.we = we; e.mis = mis; e.ill = ill; e.full = full;
    return e;
  endfunction

  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                        input logic st, input logic fl);
    valid_i = v; RegWrite_i = rw; MemToReg_i = m2r; funct3_i = f3;
    RDaddr_i = rd; ALUresult_i = alu; MemData_i = mem; stall_i = st; flush_i = fl;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef WB_INSTRET_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Push the expectation, clock once, then pop and compare #1 after the edge.
  task automatic tick(input exp_t e);
    exp_t g;
    sb.push_back(e);
    if (m_valid && !stall_i) m_cnt = m_cnt + 1'b1;
    m_valid = flush_i ? 1'b0 : (stall_i ? m_valid : valid_i);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({g.tag, "_we"},  32'(RegWrite_o),  32'(g.we));
    chk({g.tag, "_fwd"}, 32'(fwd_valid_o), 32'(g.we));
    chk({g.tag, "_mis"}, 32'(misalign_o),  32'(g.mis));
    chk({g.tag, "_ill"}, 32'(illegal_o),   32'(g.ill));
    if (g.full) begin
      chk({g.tag, "_rd"},   32'(RDaddr_o), 32'(g.rd));
      chk({g.tag, "_data"}, RDdata_o,      g.data);
    end
    chk({g.tag, "_cnt"}, 32'(instret_o), exp_cnt());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},   32'(RDaddr_o),    32'd0);
    chk({tag, "_data"}, RDdata_o,         32'd0);
    chk({tag, "_we"},   32'(RegWrite_o),  32'd0);
    chk({tag, "_fwd"},  32'(fwd_valid_o), 32'd0);
    chk({tag, "_mis"},  32'(misalign_o),  32'd0);
    chk({tag, "_ill"},  32'(illegal_o),   32'd0);
    chk({tag, "_cnt"},  32'(instret_o),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b1;
    set_in(0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b0;

    // ALU writeback, then confirm the negedge register file commit.
    set_in(1, 1, 0, 3'b000, 5'd5, 32'h12345678, 32'd0, 0, 0);
    tick(mk("add", 5'd5, 32'h12345678, 1, 0, 0, 1));
    @(negedge clk);
    #1;
    chk("rf_x5", rf[5], 32'h12345678);

    // Loads from 0x80FF7F01.
    set_in(1, 1, 1, 3'b000, 5'd6, 32'h103, M, 0, 0);
    tick(mk("lb", 5'd6, 32'hFFFFFF80, 1, 0, 0, 1));
    set_in(1, 1, 1, 3'b100, 5'd7, 32'h102, M, 0, 0);
    tick(mk("lbu", 5'd7, 32'h000000FF, 1, 0, 0, 1));
    set_in(1, 1, 1, 3'b001, 5'd8, 32'h100, M, 0, 0);
    tick(mk("lh", 5'd8, 32'h00007F01, 1, 0, 0, 1));
    set_in(1, 1, 1, 3'b101, 5'd9, 32'h102, M, 0, 0);
    tick(mk("lhu", 5'd9, 32'h000080FF, 1, 0, 0, 1));
    set_in(1, 1, 1, 3'b010, 5'd10, 32'h104, M, 0, 0);
    tick(mk("lw", 5'd10, M, 1, 0, 0, 1));

    // Faulting loads and write suppression.
    set_in(1, 1, 1, 3'b010, 5'd11, 32'h101, M, 0, 0);
    tick(mk("lw_mis", 5'd11, 32'h0, 0, 1, 0, 1));
    set_in(1, 1, 1, 3'b001, 5'd12, 32'h103, M, 0, 0);
    tick(mk("lh_mis", 5'd12, 32'h0, 0, 1, 0, 1));
    set_in(1, 1, 1, 3'b011, 5'd13, 32'h100, M, 0, 0);
    tick(mk("ld_ill", 5'd13, 32'h0, 0, 0, 1, 1));
    set_in(1, 1, 0, 3'b110, 5'd14, 32'h0000CAFE, M, 0, 0);
    tick(mk("alu_f3", 5'd14, 32'h0000CAFE, 1, 0, 0, 1));
    set_in(1, 1, 0, 3'b000, 5'd0, 32'h0000DEAD, 32'd0, 0, 0);
    tick(mk("x0", 5'd0, 32'h0000DEAD, 0, 0, 0, 1));
    set_in(1, 0, 0, 3'b000, 5'd15, 32'h1, 32'd0, 0, 0);
    tick(mk("norw", 5'd15, 32'h1, 0, 0, 0, 1));
    set_in(0, 1, 0, 3'b000, 5'd16, 32'h2, 32'd0, 0, 0);
    tick(mk("bubble", 5'd16, 32'h2, 0, 0, 0, 1));

    // Stall holds outputs with the write still asserted; flush beats stall.
    set_in(1, 1, 0, 3'b000, 5'd17, 32'hA5A5A5A5, 32'd0, 0, 0);
    tick(mk("stl_cap", 5'd17, 32'hA5A5A5A5, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 3'b000, 5'd3, 32'h0000FFFF, 32'd0, 1, 0);
      tick(mk("stl_hold", 5'd17, 32'hA5A5A5A5, 1, 0, 0, 1));
    end
    set_in(1, 1, 0, 3'b000, 5'd3, 32'h0000FFFF, 32'd0, 1, 1);
    tick(mk("stl_flush", 5'd0, 32'h0, 0, 0, 0, 0));

    // Misalign is a level flag across stalls and clears on flush.
    set_in(1, 1, 1, 3'b010, 5'd18, 32'h102, M, 0, 0);
    tick(mk("mis_cap", 5'd18, 32'h0, 0, 1, 0, 1));
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 3'b000, 5'd2, 32'h7, 32'd0, 1, 0);
      tick(mk("mis_hold", 5'd18, 32'h0, 0, 1, 0, 1));
    end
    set_in(1, 1, 1, 3'b010, 5'd19, 32'h101, M, 0, 1);
    tick(mk("mis_flush", 5'd0, 32'h0, 0, 0, 0, 0));

    // Asynchronous reset between edges.
    set_in(1, 1, 0, 3'b000, 5'd4, 32'h00000055, 32'd0, 0, 0);
    tick(mk("pre_rst", 5'd4, 32'h00000055, 1, 0, 0, 1));
    #1;
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_cnt = '0;
    #1;
    chk_zero("async_rst");
    set_in(0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Retire counting: 10 instructions, 3 stalls, 2 flushed slots.
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 3'b000, 5'd1, 32'(i), 32'd0, 0, 0);
      tick(mk("ret_add", 5'd1, 32'(i), 1, 0, 0, 1));
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 3'b000, 5'd2, 32'hBAD, 32'd0, 1, 0);
      tick(mk("ret_stall", 5'd1, 32'd9, 1, 0, 0, 1));
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 3'b000, 5'd2, 32'hBAD, 32'd0, 0, 1);
      tick(mk("ret_flush", 5'd0, 32'h0, 0, 0, 0, 0));
    end
`ifdef WB_INSTRET_EN
    chk("instret_10", 32'(instret_o), 32'd10);
`endif

    // More traffic so a narrow counter wraps through zero.
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      set_in(1, 1, 0, 3'b000, 5'(i % 31 + 1), r, 32'd0, 0, 0);
      tick(mk("wrap_add", 5'(i % 31 + 1), r, 1, 0, 0, 1));
    end
    set_in(0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 0, 0);
    tick(mk("drain", 5'd0, 32'h0, 0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
